// File: rtl/arch_sync_filter.sv
// arch_sync_filter: multi-channel async-input synchroniser with per-channel
// glitch filter, registered rise/fall pulses and a valid/ready change-mask
// event with sticky overflow.
// Build option: define ARCH_SYNC_FILTER_EN to build the stable-count glitch
// filter; left undefined, the filtered level follows the synchroniser output
// every cycle and FILTER_CYCLES is ignored.

// One channel: sync chain, optional filter, edge pulses.
module arch_sync_filter_lane #(
  parameter int unsigned SYNC_STAGES   = 3,
`ifdef ARCH_SYNC_FILTER_EN
  parameter int unsigned FILTER_CYCLES = 4,
`endif
  parameter logic        INIT          = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic async_in,
  output logic lvl_q,
  output logic rise_q,
  output logic fall_q,
  output logic chg
);
  // Chain flops must stay distinct and be placed close together.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", syn_preserve = 1 *)
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   raw;
  logic                   lvl_d;
  logic                   rise_d;
  logic                   fall_d;

  // Shift the async level down the chain.
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], async_in};

  assign raw = sync_q[SYNC_STAGES-1];

  // Chain register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sync_q <= {SYNC_STAGES{INIT}};
    else          sync_q <= sync_d;
  end

`ifdef ARCH_SYNC_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Accept a new level only after it has been seen FILTER_CYCLES times in a row.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (raw == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
      lvl_d = raw;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stable-count register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  // Unfiltered: level follows the chain output directly.
  always_comb lvl_d = raw;
`endif

  // Edge detect on the next filtered level so pulses land with the level change.
  always_comb begin
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
    chg    = rise_d | fall_d;
  end

  // Level and pulse registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lvl_q  <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
endmodule

module arch_sync_filter #(
  parameter int unsigned     WIDTH         = 2,
  parameter int unsigned     SYNC_STAGES   = 3,
  parameter int unsigned     FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] INIT         = '0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_mask,
  output logic [WIDTH-1:0] evt_level,
  output logic             evt_overflow
);
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             hs;
  logic             new_ovf;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    arch_sync_filter_lane #(
      .SYNC_STAGES  (SYNC_STAGES),
`ifdef ARCH_SYNC_FILTER_EN
      .FILTER_CYCLES(FILTER_CYCLES),
`endif
      .INIT         (INIT[i])
    ) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .async_in(async_in[i]),
      .lvl_q   (sync_out[i]),
      .rise_q  (rise_out[i]),
      .fall_q  (fall_out[i]),
      .chg     (chg[i])
    );
  end

  assign evt_valid    = |mask_q;
  assign evt_mask     = mask_q;
  assign evt_overflow = ovf_q;
  assign evt_level    = sync_out;

  // Accumulate changes; a handshake hands off the mask but keeps same-cycle changes.
  always_comb begin
    hs      = evt_valid & evt_ready;
    new_ovf = |(mask_q & chg);
    mask_d  = hs ? chg : (mask_q | chg);
    ovf_d   = hs ? new_ovf : (ovf_q | new_ovf);
  end

  // Event mask and sticky overflow registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mask_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_arch_sync_filter.sv
// Directed bench for arch_sync_filter (WIDTH=2, SYNC_STAGES=3, FILTER_CYCLES=4).
// Expected timing follows ARCH_SYNC_FILTER_EN the same way the design does.
module tb_arch_sync_filter;
  localparam int WIDTH         = 2;
  localparam int SYNC_STAGES   = 3;
  localparam int FILTER_CYCLES = 4;
`ifdef ARCH_SYNC_FILTER_EN
  localparam int LAT  = SYNC_STAGES + FILTER_CYCLES - 1;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = SYNC_STAGES;
  localparam bit FILT = 1'b0;
`endif

  logic             aclk;
  logic             aresetn;
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_mask;
  logic [WIDTH-1:0] evt_level;
  logic             evt_overflow;

  int errors = 0;
  int checks = 0;

  arch_sync_filter #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES), .INIT(2'b00)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .async_in(async_in), .sync_out(sync_out),
    .rise_out(rise_out), .fall_out(fall_out), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_mask(evt_mask), .evt_level(evt_level),
    .evt_overflow(evt_overflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; async_in = '0; evt_ready = 1'b0;
    tick(2);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; async_in = '0; evt_ready = 1'b0;
    tick(3);
    checks++;
    if ({sync_out, rise_out, fall_out, evt_mask, evt_valid, evt_overflow} !== 10'b0) begin
      errors++;
      $display("FAIL reset_hold: got s=%b r=%b f=%b m=%b v=%b o=%b want all 0",
               sync_out, rise_out, fall_out, evt_mask, evt_valid, evt_overflow);
    end
    aresetn = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      checks++;
      if ({sync_out, rise_out, fall_out, evt_mask, evt_valid, evt_overflow, evt_level} !== 12'b0) begin
        errors++;
        $display("FAIL reset_release c%0d: got s=%b r=%b f=%b m=%b v=%b o=%b l=%b want all 0", t,
                 sync_out, rise_out, fall_out, evt_mask, evt_valid, evt_overflow, evt_level);
      end
    end
  endtask

  task automatic test_step();
    async_in = 2'b01;
    tick(LAT);
    checks++;
    if ({sync_out, rise_out, evt_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL step_early: got s=%b r=%b v=%b want s=00 r=00 v=0", sync_out, rise_out, evt_valid);
    end
    tick(1);
    checks++;
    if ({sync_out, rise_out, fall_out, evt_level} !== 8'b01010001) begin
      errors++;
      $display("FAIL step_edge: got s=%b r=%b f=%b l=%b want s=01 r=01 f=00 l=01",
               sync_out, rise_out, fall_out, evt_level);
    end
    checks++;
    if ({evt_valid, evt_mask, evt_overflow} !== 4'b1010) begin
      errors++;
      $display("FAIL step_evt: got v=%b m=%b o=%b want v=1 m=01 o=0", evt_valid, evt_mask, evt_overflow);
    end
    tick(1);
    checks++;
    if ({sync_out, rise_out, evt_valid, evt_mask} !== 7'b0100101) begin
      errors++;
      $display("FAIL step_after: got s=%b r=%b v=%b m=%b want s=01 r=00 v=1 m=01",
               sync_out, rise_out, evt_valid, evt_mask);
    end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    checks++;
    if ({evt_valid, evt_mask, evt_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL step_hs: got v=%b m=%b o=%b want v=0 m=00 o=0", evt_valid, evt_mask, evt_overflow);
    end
  endtask

  // Drive a p-cycle pulse on channel ch over a static base and check every cycle.
  task automatic run_pulse(input int ch, input int p, input logic [WIDTH-1:0] base);
    logic             pass;
    logic [WIDTH-1:0] bm, es, er, ef;
    pass = !FILT || (p >= FILTER_CYCLES);
    bm = '0;
    bm[ch] = 1'b1;
    for (int t = 1; t <= LAT + p + 4; t++) begin
      async_in = (t <= p) ? (base | bm) : base;
      tick(1);
      es = (pass && t > LAT && t <= LAT + p) ? (base | bm) : base;
      er = (pass && t == LAT + 1) ? bm : '0;
      ef = (pass && t == LAT + 1 + p) ? bm : '0;
      checks++;
      if ({sync_out, rise_out, fall_out} !== {es, er, ef}) begin
        errors++;
        $display("FAIL pulse ch%0d p%0d t%0d: got s=%b r=%b f=%b want s=%b r=%b f=%b",
                 ch, p, t, sync_out, rise_out, fall_out, es, er, ef);
      end
    end
    checks++;
    if ({evt_valid, evt_mask, evt_overflow} !== {pass, (pass ? bm : 2'b00), pass}) begin
      errors++;
      $display("FAIL pulse_evt ch%0d p%0d: got v=%b m=%b o=%b want v=%b m=%b o=%b", ch, p,
               evt_valid, evt_mask, evt_overflow, pass, (pass ? bm : 2'b00), pass);
    end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    checks++;
    if ({evt_valid, evt_mask, evt_overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL pulse_clear ch%0d p%0d: got v=%b m=%b o=%b want 0 00 0", ch, p,
               evt_valid, evt_mask, evt_overflow);
    end
  endtask

  task automatic test_glitch();
    run_pulse(1, 3, 2'b01);
    run_pulse(1, 4, 2'b01);
    run_pulse(1, 1, 2'b01);
  endtask

  task automatic test_overflow();
    do_reset();
    async_in = 2'b01;
    tick(8);
    async_in = 2'b00;
    tick(LAT + 4);
    checks++;
    if ({sync_out, evt_valid, evt_mask, evt_overflow} !== 6'b001011) begin
      errors++;
      $display("FAIL ovf_set: got s=%b v=%b m=%b o=%b want s=00 v=1 m=01 o=1",
               sync_out, evt_valid, evt_mask, evt_overflow);
    end
    tick(3);
    checks++;
    if ({evt_valid, evt_mask, evt_overflow} !== 4'b1011) begin
      errors++;
      $display("FAIL ovf_sticky: got v=%b m=%b o=%b want v=1 m=01 o=1", evt_valid, evt_mask, evt_overflow);
    end
    async_in = 2'b10;
    tick(LAT);
    checks++;
    if ({rise_out, evt_mask} !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_pre_hs: got r=%b m=%b want r=00 m=01", rise_out, evt_mask);
    end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    checks++;
    if ({rise_out, evt_valid, evt_mask, evt_overflow} !== 6'b101100) begin
      errors++;
      $display("FAIL ovf_hs_same_cycle: got r=%b v=%b m=%b o=%b want r=10 v=1 m=10 o=0",
               rise_out, evt_valid, evt_mask, evt_overflow);
    end
    tick(1);
    checks++;
    if ({rise_out, evt_valid, evt_mask, evt_overflow, sync_out} !== 8'b00110010) begin
      errors++;
      $display("FAIL ovf_hold: got r=%b v=%b m=%b o=%b s=%b want r=00 v=1 m=10 o=0 s=10",
               rise_out, evt_valid, evt_mask, evt_overflow, sync_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    async_in = 2'b10;
    tick(LAT + 1);
    checks++;
    if ({sync_out, rise_out, evt_mask} !== 6'b101010) begin
      errors++;
      $display("FAIL mid_pending: got s=%b r=%b m=%b want s=10 r=10 m=10", sync_out, rise_out, evt_mask);
    end
    async_in = 2'b11;
    tick(LAT - 1);
    checks++;
    if (sync_out !== 2'b10) begin
      errors++;
      $display("FAIL mid_partial: got s=%b want 10", sync_out);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({sync_out, rise_out, fall_out, evt_mask, evt_valid, evt_overflow} !== 10'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got s=%b r=%b f=%b m=%b v=%b o=%b want all 0",
               sync_out, rise_out, fall_out, evt_mask, evt_valid, evt_overflow);
    end
    tick(2);
    aresetn = 1'b1;
    tick(LAT);
    checks++;
    if ({sync_out, rise_out, evt_valid} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_relatency: got s=%b r=%b v=%b want s=00 r=00 v=0", sync_out, rise_out, evt_valid);
    end
    tick(1);
    checks++;
    if ({sync_out, rise_out, evt_valid, evt_mask} !== 7'b1111111) begin
      errors++;
      $display("FAIL mid_both: got s=%b r=%b v=%b m=%b want s=11 r=11 v=1 m=11",
               sync_out, rise_out, evt_valid, evt_mask);
    end
    tick(1);
    checks++;
    if ({rise_out, fall_out, evt_overflow} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_after: got r=%b f=%b o=%b want r=00 f=00 o=0", rise_out, fall_out, evt_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
